// File: rtl/playback_sched_pkg.sv
// Shared constants, FSM state encoding and mix saturation for the playback scheduler.
package playback_sched_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FETCH,
        DONE
    } state_t;

    // Clamp a sign-extended accumulator to the signed DATA_W range.
    function automatic logic [DATA_W-1:0] saturate(input logic signed [31:0] acc);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (DATA_W - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (acc > hi) begin
            saturate = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (acc < lo) begin
            saturate = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            saturate = acc[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/playback_sched_voice_alloc.sv
// Per-voice pointer/end/active registers with free-voice allocation and round-robin stealing.
module voice_alloc #(
    parameter int VOICES = 4,
    parameter int ADDR_W = playback_sched_pkg::ADDR_W,
    localparam int IDX_W = $clog2(VOICES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    input  logic [ADDR_W-1:0] alloc_start,
    input  logic [ADDR_W-1:0] alloc_end,
    input  logic [IDX_W-1:0]  sel,
    input  logic              advance,
    input  logic              clear,
    output logic [ADDR_W-1:0] sel_ptr,
    output logic [ADDR_W-1:0] sel_end,
    output logic              alloc_fire,
    output logic [IDX_W-1:0]  alloc_idx,
    output logic [VOICES-1:0] active
);
    import playback_sched_pkg::*;

    logic [ADDR_W-1:0] ptr      [VOICES];
    logic [ADDR_W-1:0] end_addr [VOICES];
    logic [IDX_W-1:0]  steal_ptr;
    logic [IDX_W-1:0]  free_idx;
    logic              any_free;

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!active[i] && !any_free) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    assign alloc_fire = alloc_req && (alloc_start < alloc_end);
    assign alloc_idx  = any_free ? free_idx : steal_ptr;
    assign sel_ptr    = ptr[sel];
    assign sel_end    = end_addr[sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            steal_ptr <= '0;
        end else if (alloc_fire && !any_free) begin
            steal_ptr <= steal_ptr + IDX_W'(1);
        end
    end

    // A new allocation takes priority over an advance/clear on the same voice.
    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (reset) begin
                ptr[v]      <= '0;
                end_addr[v] <= '0;
                active[v]   <= 1'b0;
            end else if (alloc_fire && alloc_idx == IDX_W'(v)) begin
                ptr[v]      <= alloc_start;
                end_addr[v] <= alloc_end;
                active[v]   <= 1'b1;
            end else if (advance && sel == IDX_W'(v)) begin
                ptr[v] <= ptr[v] + ADDR_W'(1);
                if (clear) begin
                    active[v] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/playback_sched.sv
// Multi-voice playback scheduler: per-tick scan of active voices, one memory read each, saturated mix.
module playback_sched #(
    parameter int VOICES = 4,
    parameter int ADDR_W = playback_sched_pkg::ADDR_W,
    parameter int DATA_W = playback_sched_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger_playback,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [ADDR_W-1:0] end_in,
    input  logic              sample_tick,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] mix_out,
    output logic              mix_valid,
    output logic [VOICES-1:0] voices_active,
    output logic              overrun
);
    import playback_sched_pkg::*;

    localparam int IDX_W = $clog2(VOICES);
    localparam int ACC_W = DATA_W + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(VOICES - 1);

    state_t                   state, state_nxt;
    logic [IDX_W-1:0]         v, v_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic [ADDR_W-1:0]        addr_q;
    logic                     realloc;
    logic                     start_tick, enter_fetch, take_ack;
    logic                     advance, clear;
    logic [ADDR_W-1:0]        sel_ptr, sel_end;
    logic                     alloc_fire;
    logic [IDX_W-1:0]         alloc_idx;
    logic                     realloc_hit;

    voice_alloc #(
        .VOICES (VOICES),
        .ADDR_W (ADDR_W)
    ) u_alloc (
        .clk         (clk),
        .reset       (reset),
        .alloc_req   (trigger_playback),
        .alloc_start (address_in),
        .alloc_end   (end_in),
        .sel         (v),
        .advance     (advance),
        .clear       (clear),
        .sel_ptr     (sel_ptr),
        .sel_end     (sel_end),
        .alloc_fire  (alloc_fire),
        .alloc_idx   (alloc_idx),
        .active      (voices_active)
    );

    // A voice reallocated while its read is in flight keeps its new pointer untouched by the ack.
    assign realloc_hit = alloc_fire && (alloc_idx == v);
    assign advance     = take_ack && !realloc;
    assign clear       = (sel_ptr + ADDR_W'(1)) == sel_end;
    assign mem_rd_addr = addr_q;
    assign mix_out     = saturate(32'(acc));

    always_comb begin
        state_nxt   = state;
        v_nxt       = v;
        mem_rd_req  = 1'b0;
        mix_valid   = 1'b0;
        start_tick  = 1'b0;
        enter_fetch = 1'b0;
        take_ack    = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_tick) begin
                    start_tick = 1'b1;
                    v_nxt      = '0;
                    state_nxt  = SCAN;
                end
            end
            SCAN: begin
                if (voices_active[v]) begin
                    enter_fetch = 1'b1;
                    state_nxt   = FETCH;
                end else if (v == LAST) begin
                    state_nxt = DONE;
                end else begin
                    v_nxt = v + IDX_W'(1);
                end
            end
            FETCH: begin
                mem_rd_req = 1'b1;
                if (mem_rd_ack) begin
                    take_ack = 1'b1;
                    if (v == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        v_nxt     = v + IDX_W'(1);
                        state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                mix_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            v       <= '0;
            acc     <= '0;
            addr_q  <= '0;
            realloc <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            v     <= v_nxt;
            if (sample_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (start_tick) begin
                acc <= '0;
            end else if (take_ack) begin
                acc <= acc + {{(ACC_W - DATA_W){mem_rd_data[DATA_W-1]}}, mem_rd_data};
            end
            if (enter_fetch) begin
                addr_q  <= sel_ptr;
                realloc <= realloc_hit;
            end else if (state == FETCH && realloc_hit) begin
                realloc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_playback_sched.sv
// Directed self-checking bench for playback_sched with a hand-driven memory responder.
module tb_playback_sched;

    localparam int VOICES = 4;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              trigger_playback = 1'b0;
    logic [ADDR_W-1:0] address_in = '0;
    logic [ADDR_W-1:0] end_in = '0;
    logic              sample_tick = 1'b0;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack = 1'b0;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic [DATA_W-1:0] mix_out;
    logic              mix_valid;
    logic [VOICES-1:0] voices_active;
    logic              overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_tick = 0;
    int mv_cnt = 0;
    int rq_cnt = 0;
    int mark = 0;

    playback_sched #(
        .VOICES (VOICES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .trigger_playback (trigger_playback),
        .address_in       (address_in),
        .end_in           (end_in),
        .sample_tick      (sample_tick),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_ack       (mem_rd_ack),
        .mem_rd_data      (mem_rd_data),
        .mix_out          (mix_out),
        .mix_valid        (mix_valid),
        .voices_active    (voices_active),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mix_valid) mv_cnt <= mv_cnt + 1;
        if (mem_rd_req) rq_cnt <= rq_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic trig(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] e);
        trigger_playback = 1'b1;
        address_in = a;
        end_in = e;
        step();
        trigger_playback = 1'b0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        t_tick = cyc;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic serve(input string tag, input int dly, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] a);
        int n = 0;
        while (mem_rd_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 64'(mem_rd_req), 64'd1);
        chk({tag, "_addr"}, 64'(mem_rd_addr), 64'(a));
        repeat (dly) step();
        mem_rd_ack = 1'b1;
        mem_rd_data = d;
        step();
        mem_rd_ack = 1'b0;
        mem_rd_data = '0;
    endtask

    task automatic wait_mix(input string tag, input logic [DATA_W-1:0] exp, input int lat);
        int n = 0;
        while (mix_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(mix_valid), 64'd1);
        chk({tag, "_mix"}, 64'(mix_out), 64'(exp));
        chk({tag, "_lat"}, 64'(cyc - t_tick), 64'(lat));
        step();
    endtask

    initial begin
        repeat (2) step();
        reset = 1'b0;
        chk("rst_req", 64'(mem_rd_req), 64'd0);
        chk("rst_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_valid", 64'(mix_valid), 64'd0);
        chk("rst_mix", 64'(mix_out), 64'd0);
        chk("rst_active", 64'(voices_active), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Single voice, one-word sample; ack after 2 wait cycles gives F=3.
        trig(27'h100, 27'h101);
        chk("t1_active", 64'(voices_active), 64'h1);
        tick();
        serve("t1", 2, 16'h1234, 27'h100);
        chk("t1_cleared", 64'(voices_active), 64'h0);
        wait_mix("t1", 16'h1234, 8);
        mark = rq_cnt;
        tick();
        wait_mix("t1b", 16'h0000, 5);
        chk("t1b_noread", 64'(rq_cnt - mark), 64'd0);

        // Empty or inverted ranges are ignored.
        trig(27'h200, 27'h200);
        chk("ign_eq", 64'(voices_active), 64'h0);
        trig(27'h300, 27'h200);
        chk("ign_gt", 64'(voices_active), 64'h0);

        // Saturation: 4 x 0x7000 and 4 x 0x9000.
        trig(27'h400, 27'h410);
        trig(27'h500, 27'h510);
        trig(27'h600, 27'h610);
        trig(27'h700, 27'h710);
        chk("sat_active", 64'(voices_active), 64'hF);
        tick();
        serve("satp0", 0, 16'h7000, 27'h400);
        serve("satp1", 0, 16'h7000, 27'h500);
        serve("satp2", 0, 16'h7000, 27'h600);
        serve("satp3", 0, 16'h7000, 27'h700);
        wait_mix("satp", 16'h7FFF, 9);
        tick();
        serve("satn0", 0, 16'h9000, 27'h401);
        serve("satn1", 0, 16'h9000, 27'h501);
        serve("satn2", 0, 16'h9000, 27'h601);
        serve("satn3", 0, 16'h9000, 27'h701);
        wait_mix("satn", 16'h8000, 9);
        chk("sat_no_overrun", 64'(overrun), 64'd0);

        // Second tick while the first read is still pending.
        mark = mv_cnt;
        tick();
        step();
        chk("ov_req", 64'(mem_rd_req), 64'd1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("ov_flag", 64'(overrun), 64'd1);
        serve("ov0", 0, 16'h0001, 27'h402);
        serve("ov1", 0, 16'h0001, 27'h502);
        serve("ov2", 0, 16'h0001, 27'h602);
        serve("ov3", 0, 16'h0001, 27'h702);
        wait_mix("ov", 16'h0004, 10);
        repeat (10) step();
        chk("ov_one_pulse", 64'(mv_cnt - mark), 64'd1);
        chk("ov_sticky", 64'(overrun), 64'd1);

        // Reset while a read is outstanding, then a late ack.
        tick();
        step();
        chk("rm_req_pre", 64'(mem_rd_req), 64'd1);
        chk("rm_addr_pre", 64'(mem_rd_addr), 64'h403);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rm_req", 64'(mem_rd_req), 64'd0);
        chk("rm_addr", 64'(mem_rd_addr), 64'd0);
        chk("rm_active", 64'(voices_active), 64'h0);
        chk("rm_valid", 64'(mix_valid), 64'd0);
        chk("rm_overrun", 64'(overrun), 64'd0);
        mem_rd_ack = 1'b1;
        mem_rd_data = 16'h1111;
        step();
        mem_rd_ack = 1'b0;
        mem_rd_data = '0;
        chk("rm_late_mix", 64'(mix_out), 64'd0);
        chk("rm_late_req", 64'(mem_rd_req), 64'd0);
        mark = rq_cnt;
        tick();
        wait_mix("rm_idle", 16'h0000, 5);
        chk("rm_noread", 64'(rq_cnt - mark), 64'd0);

        // Voice steal: fifth request replaces voice 0, sixth replaces voice 1.
        trig(27'h10, 27'h18);
        trig(27'h20, 27'h28);
        trig(27'h30, 27'h38);
        trig(27'h40, 27'h48);
        trig(27'h50, 27'h58);
        chk("st_active", 64'(voices_active), 64'hF);
        tick();
        serve("st0", 0, 16'h0010, 27'h50);
        serve("st1", 0, 16'h0020, 27'h20);
        serve("st2", 0, 16'h0030, 27'h30);
        serve("st3", 0, 16'h0040, 27'h40);
        wait_mix("st", 16'h00A0, 9);
        trig(27'h60, 27'h68);
        tick();
        serve("st4", 0, 16'h0001, 27'h51);
        serve("st5", 0, 16'h0002, 27'h60);
        serve("st6", 0, 16'h0003, 27'h31);
        serve("st7", 0, 16'h0004, 27'h41);
        wait_mix("st2nd", 16'h000A, 9);

        // Reallocation of the voice whose read is in flight.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        trig(27'h107, 27'h108);
        trig(27'h900, 27'h910);
        trig(27'hA00, 27'hA10);
        trig(27'hB00, 27'hB10);
        chk("ra_active", 64'(voices_active), 64'hF);
        tick();
        step();
        chk("ra_req", 64'(mem_rd_req), 64'd1);
        chk("ra_addr", 64'(mem_rd_addr), 64'h107);
        trigger_playback = 1'b1;
        address_in = 27'h300;
        end_in = 27'h310;
        step();
        trigger_playback = 1'b0;
        chk("ra_addr_hold", 64'(mem_rd_addr), 64'h107);
        chk("ra_req_hold", 64'(mem_rd_req), 64'd1);
        mem_rd_ack = 1'b1;
        mem_rd_data = 16'h0100;
        step();
        mem_rd_ack = 1'b0;
        mem_rd_data = '0;
        chk("ra_active_after", 64'(voices_active), 64'hF);
        serve("ra1", 1, 16'h0100, 27'h900);
        serve("ra2", 1, 16'h0100, 27'hA00);
        serve("ra3", 1, 16'h0100, 27'hB00);
        wait_mix("ra", 16'h0400, 13);
        tick();
        serve("ra4", 0, 16'h0001, 27'h300);
        serve("ra5", 0, 16'h0001, 27'h901);
        serve("ra6", 0, 16'h0001, 27'hA01);
        serve("ra7", 0, 16'h0001, 27'hB01);
        wait_mix("ra2nd", 16'h0004, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
